compf_pipe: RTL and testbench

- Pipelined, parametrised floating-point comparator for the float unit. Successor to the single-precision combinational compare.
- Adds: configurable exponent/mantissa widths, LANES parallel lanes, valid/ready handshake with backpressure, and extended ops (GE, LE, NE, MIN, MAX).
- Ordering is correct for negative operands: larger magnitude with sign 1 is less.

---
 rtl/compf_pipe.sv | 145 ++++++++++++++
 tb/tb_compf_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/compf_pipe.sv
// ============================================================================
// Module   : compf_pipe
// Brief    : Two-stage, multi-lane floating-point compare / MIN / MAX with a
//            valid-ready handshake. Define COMPF_NAN_EN for NaN handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compf_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int LANES  = 1,
  localparam int W     = 1 + EXP_W + MANT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  input  logic [2:0]         inst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   s,
  output logic [LANES*W-1:0] res,
  output logic [LANES-1:0]   nan
);

  localparam logic [2:0] OP_NE = 3'b010;

  logic               en;
  logic               v1_q, v2_q;
  logic [LANES*W-1:0] a1_q, b1_q;
  logic [2:0]         inst1_q;
  logic [LANES-1:0]   s_d, s_q, nan_d, nan_q;
  logic [LANES*W-1:0] res_d, res_q;

  // Single global advance: every stage moves or every stage holds.
  assign en = !v2_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      inst1_q <= '0;
      s_q     <= '0;
      res_q   <= '0;
      nan_q   <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) begin
        a1_q    <= a;
        b1_q    <= b;
        inst1_q <= inst;
      end
      if (v1_q) begin
        s_q   <= s_d;
        res_q <= res_d;
        nan_q <= nan_d;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] la, lb, lres;
    logic [W-2:0] ma, mb;
    logic         sa, sb, both_zero, eq, gt, lt, is_mm, pred, ls, lnan;

    assign la = a1_q[i*W +: W];
    assign lb = b1_q[i*W +: W];
    assign sa = la[W-1];
    assign sb = lb[W-1];
    assign ma = la[W-2:0];
    assign mb = lb[W-2:0];

`ifdef COMPF_NAN_EN
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    logic nan_a, nan_b;
    assign nan_a = (&la[W-2 -: EXP_W]) && (la[MANT_W-1:0] != '0);
    assign nan_b = (&lb[W-2 -: EXP_W]) && (lb[MANT_W-1:0] != '0);
`endif

    always_comb begin
      both_zero = (ma == '0) && (mb == '0);
      eq        = both_zero || (la == lb);
      // Negative operands order by reversed magnitude.
      if (both_zero)     gt = 1'b0;
      else if (sa != sb) gt = sb;
      else if (!sa)      gt = (ma > mb);
      else               gt = (ma < mb);
      lt    = !eq && !gt;
      is_mm = (inst1_q[2:1] == 2'b00);
      pred  = 1'b0;
      case (inst1_q)
        3'b100: pred = eq;
        3'b110: pred = gt;
        3'b101: pred = lt;
        3'b111: pred = gt || eq;
        3'b011: pred = lt || eq;
        3'b010: pred = !eq;
        3'b000: pred = !gt;   // MIN keeps a on ties
        3'b001: pred = !lt;   // MAX keeps a on ties
        default: pred = 1'b0;
      endcase
      ls   = pred;
      lres = (is_mm && !pred) ? lb : la;
      lnan = 1'b0;
`ifdef COMPF_NAN_EN
      if (nan_a || nan_b) begin
        lnan = 1'b1;
        lres = la;
        ls   = (inst1_q == OP_NE);
        if (is_mm) begin
          if (nan_a && nan_b) begin
            ls   = 1'b0;
            lres = QNAN;
          end else if (nan_a) begin
            ls   = 1'b0;
            lres = lb;
          end else begin
            ls   = 1'b1;
            lres = la;
          end
        end
      end
`endif
    end

    assign s_d[i]           = ls;
    assign nan_d[i]         = lnan;
    assign res_d[i*W +: W]  = lres;
  end

  assign in_ready  = en;
  assign out_valid = v2_q;
  assign s         = s_q;
  assign res       = res_q;
  assign nan       = nan_q;

endmodule

`default_nettype wire

// File: tb/tb_compf_pipe.sv
// ============================================================================
// Module   : tb_compf_pipe
// Brief    : Directed self-checking bench for compf_pipe (LANES=1 and LANES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compf_pipe;

  localparam logic [2:0] OP_EQ = 3'b100, OP_GT = 3'b110, OP_LT = 3'b101,
                         OP_GE = 3'b111, OP_LE = 3'b011, OP_NE = 3'b010,
                         OP_MIN = 3'b000, OP_MAX = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [31:0] a1 = '0, b1 = '0, res1;
  logic [2:0]  inst1 = '0;
  logic [0:0]  s1, nan1;

  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [127:0] a4 = '0, b4 = '0, res4;
  logic [2:0]   inst4 = '0;
  logic [3:0]   s4, nan4;

  int n_tests = 0;
  int n_fail  = 0;

  compf_pipe #(.EXP_W(8), .MANT_W(23), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .inst(inst1), .out_valid(out_valid1),
    .out_ready(out_ready1), .s(s1), .res(res1), .nan(nan1)
  );

  compf_pipe #(.EXP_W(8), .MANT_W(23), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .inst(inst4), .out_valid(out_valid4),
    .out_ready(out_ready4), .s(s4), .res(res4), .nan(nan4)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One beat through dut1 with out_ready high; result due two edges after accept.
  task automatic run1(input string tag, input logic [2:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input logic es, input logic [31:0] er,
                      input logic en_exp);
    @(negedge clk);
    out_ready1 = 1'b1;
    in_valid1  = 1'b1;
    inst1      = op;
    a1         = av;
    b1         = bv;
    #1 check({tag, "_inrdy"}, in_ready1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    #1 check({tag, "_lat1"}, out_valid1, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_vld"}, out_valid1, 1'b1);
    check({tag, "_s"},   s1,   es);
    check({tag, "_res"}, res1, er);
    check({tag, "_nan"}, nan1, en_exp);
  endtask

  logic [31:0] bp_a  [4] = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'h00000000};
  logic [31:0] bp_b  [4] = '{32'h40000000, 32'hC0000000, 32'h40400000, 32'h80000000};
  logic [31:0] bp_er [4] = '{32'h40000000, 32'hBF800000, 32'h40400000, 32'h00000000};
  logic        bp_es [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ovld", out_valid1, 1'b0);
    check("rst_irdy", in_ready1, 1'b1);
    check("rst_s",    s1,   1'b0);
    check("rst_res",  res1, 32'h0);
    check("rst_nan",  nan1, 1'b0);

    run1("gt_pos",   OP_GT,  32'h40000000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0);
    run1("lt_neg",   OP_LT,  32'hC0000000, 32'hBF800000, 1'b1, 32'hC0000000, 1'b0);
    run1("gt_neg",   OP_GT,  32'hC0000000, 32'hBF800000, 1'b0, 32'hC0000000, 1'b0);
    run1("eq_zero",  OP_EQ,  32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0);
    run1("min_zero", OP_MIN, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0);
    run1("le_sign",  OP_LE,  32'h3F800000, 32'hBF800000, 1'b0, 32'h3F800000, 1'b0);
    run1("ne_same",  OP_NE,  32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
    run1("min_sign", OP_MIN, 32'h40000000, 32'hC0000000, 1'b0, 32'hC0000000, 1'b0);
`ifdef COMPF_NAN_EN
    run1("nan_eq",   OP_EQ,  32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00001, 1'b1);
    run1("nan_ne",   OP_NE,  32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00001, 1'b1);
    run1("nan_max",  OP_MAX, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b1);
    run1("nan_both", OP_MIN, 32'h7FC00001, 32'h7F800001, 1'b0, 32'h7FC00000, 1'b1);
`else
    run1("raw_eq",   OP_EQ,  32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00001, 1'b0);
    run1("raw_gt",   OP_GT,  32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00001, 1'b0);
    run1("raw_max",  OP_MAX, 32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00001, 1'b0);
`endif

    // Backpressure: stall the sink for three cycles once the first result shows.
    begin
      int sent = 0;
      int got  = 0;
      int stall = -1;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        if (stall < 0 && out_valid1) stall = 3;
        out_ready1 = !(stall > 0);
        if (sent < 4) begin
          in_valid1 = 1'b1;
          inst1     = OP_MAX;
          a1        = bp_a[sent];
          b1        = bp_b[sent];
        end else begin
          in_valid1 = 1'b0;
        end
        #1;
        if (stall > 0) begin
          check("bp_inrdy", in_ready1, 1'b0);
          check("bp_hold",  {out_valid1, res1}, {1'b1, bp_er[got]});
          stall--;
        end
        if (out_valid1 && out_ready1) begin
          check("bp_res", res1, bp_er[got]);
          check("bp_s",   s1,   bp_es[got]);
          got++;
        end
        if (in_valid1 && in_ready1) sent++;
      end
      in_valid1  = 1'b0;
      out_ready1 = 1'b1;
      check("bp_count", got, 4);
    end

    // LANES=4: reset with two beats in flight, then a multi-lane GE.
    @(negedge clk);
    in_valid4 = 1'b1;
    inst4     = OP_GE;
    a4        = {4{32'h3F800000}};
    b4        = {4{32'h40000000}};
    @(negedge clk);
    a4 = {4{32'hC0000000}};
    @(negedge clk);
    in_valid4 = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    #1;
    check("l4_rst_ovld", out_valid4, 1'b0);
    check("l4_rst_irdy", in_ready4, 1'b1);
    check("l4_rst_s",    s4, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    #1 check("l4_idle_ovld", out_valid4, 1'b0);

    @(negedge clk);
    in_valid4 = 1'b1;
    inst4     = OP_GE;
    a4        = {32'h00000000, 32'hBF800000, 32'h3F800000, 32'h3F800000};
    b4        = {32'h80000000, 32'hC0000000, 32'h40000000, 32'h3F800000};
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    #1;
    check("l4_vld", out_valid4, 1'b1);
    check("l4_s",   s4, 4'b1101);
    check("l4_res", res4, {32'h00000000, 32'hBF800000, 32'h3F800000, 32'h3F800000});
    check("l4_nan", nan4, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
